// File: rtl/uart_transmitter.sv
// uart_transmitter: 8E1 UART serialiser (start, 8 data bits LSB first, even parity, stop)
// fed by a valid/ready byte port. Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry FIFO ahead of it.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_signal,
    output logic       out_busy
);
    localparam int            BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic          out_q, out_d;
    logic          busy_q, busy_d;
    logic          baud_last;
    logic          byte_avail;
    logic [7:0]    byte_data;

`ifdef UART_TX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [7:0]  mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   count_q, count_d;
    logic          push, pop;

    assign in_ready   = (count_q != (PW+1)'(FIFO_DEPTH)) && !reset;
    assign push       = in_valid && in_ready;
    assign byte_avail = (count_q != {(PW+1){1'b0}});
    assign byte_data  = mem_q[rd_q];
    assign pop        = (state_q == S_IDLE) && byte_avail;

    // FIFO next-state: pointers wrap naturally because the depth is a power of two
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push) begin
            mem_d[wr_q] = in_data;
            wr_d        = wr_q + PW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end else begin
            rd_d = rd_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage and pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= {PW{1'b0}};
            rd_q    <= {PW{1'b0}};
            count_q <= {(PW+1){1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end
`else
    assign in_ready   = (state_q == S_IDLE) && !reset;
    assign byte_avail = in_valid && in_ready;
    assign byte_data  = in_data;

    // FIFO_DEPTH only shapes the optional FIFO
    if (FIFO_DEPTH < 2) begin : g_depth_unused
    end
`endif

    assign baud_last = (baud_q == BAUD_LAST);

    // Frame sequencer; line and busy outputs are registered from the current state
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        out_d    = 1'b1;
        busy_d   = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                out_d = 1'b1;
                if (byte_avail) begin
                    shift_d  = byte_data;
                    parity_d = even_parity(byte_data);
                    baud_d   = {BW{1'b0}};
                    bit_d    = 3'd0;
                    state_d  = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                out_d = 1'b0;
                if (baud_last) begin
                    baud_d  = {BW{1'b0}};
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                out_d = shift_q[0];
                if (baud_last) begin
                    baud_d  = {BW{1'b0}};
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = S_PARITY;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_PARITY: begin
                out_d = parity_q;
                if (baud_last) begin
                    baud_d  = {BW{1'b0}};
                    state_d = S_STOP;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                out_d = 1'b1;
                if (baud_last) begin
                    baud_d  = {BW{1'b0}};
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                out_d   = 1'b1;
                baud_d  = {BW{1'b0}};
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= {BW{1'b0}};
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
            parity_q <= 1'b0;
            out_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
        end
    end

    assign out_signal = out_q;
    assign out_busy   = busy_q;

endmodule
